// File: rtl/delay_pipe_credit_sink_if.sv
// delay_pipe_credit_sink_if: issue/credit, pipe input and valid/ready output bundle
interface delay_pipe_credit_sink_if #(
  parameter int W = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          issue;
  logic          credit_avail;
  logic [CW-1:0] credit_r;
  logic [W-1:0]  in;
  logic          in_vld;
  logic [W-1:0]  out_r;
  logic          out_vld_r;
  logic          out_rdy;
  logic [CW-1:0] occ_r;
  logic          err_ovf_r;
  logic          err_credit_r;
  modport master (
    output issue, in, in_vld, out_rdy,
    input  credit_avail, credit_r, out_r, out_vld_r, occ_r, err_ovf_r, err_credit_r
  );
  modport slave (
    input  issue, in, in_vld, out_rdy,
    output credit_avail, credit_r, out_r, out_vld_r, occ_r, err_ovf_r, err_credit_r
  );
endinterface

// File: rtl/delay_pipe_credit_sink.sv
// delay_pipe_credit_sink: credit-gated receive FIFO turning a valid-only pipe output into valid/ready
module delay_pipe_credit_sink #(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  delay_pipe_credit_sink_if.slave b
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0] occ, occ_nxt, credit;
  logic          vld, err_ovf, err_credit;
  logic          push, pop, full, push_acc, issue_acc;
  always_comb begin
    push      = b.in_vld;
    pop       = vld & b.out_rdy;
    full      = occ == CW'(DEPTH);
    push_acc  = push & (~full | pop);
    issue_acc = b.issue & (credit != '0);
    wr_nxt    = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    rd_nxt    = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    occ_nxt   = occ + CW'(push_acc) - CW'(pop);
  end
  // storage is deliberately unreset; out_r is don't-care while empty
  always_ff @(posedge clk)
    if (rst_n && push_acc) mem[wr_ptr] <= b.in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit     <= CW'(DEPTH);
      occ        <= '0;
      vld        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_ovf    <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_nxt;
      if (pop) rd_ptr <= rd_nxt;
      occ    <= occ_nxt;
      vld    <= occ_nxt != '0;
      credit <= credit - CW'(issue_acc) + CW'(pop);
      if (push & ~push_acc) err_ovf <= 1'b1;
      if (b.issue & ~issue_acc) err_credit <= 1'b1;
    end
  end
  assign b.credit_avail = credit != '0;
  assign b.credit_r     = credit;
  assign b.out_r        = mem[rd_ptr];
  assign b.out_vld_r    = vld;
  assign b.occ_r        = occ;
  assign b.err_ovf_r    = err_ovf;
  assign b.err_credit_r = err_credit;
endmodule

// File: tb/tb_delay_pipe_credit_sink.sv
// tb_delay_pipe_credit_sink: directed vector table plus a streaming sequence for the credit sink
module tb_delay_pipe_credit_sink;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  delay_pipe_credit_sink_if #(.W(32), .DEPTH(8)) b ();
  delay_pipe_credit_sink #(.W(32), .DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  typedef struct {
    logic        rst_n, issue, in_vld, out_rdy;
    logic [31:0] din;
    logic [3:0]  credit, occ;
    logic        vld, ovf, cerr;
    logic [31:0] dout;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic r, input logic iss, input logic iv, input logic rdy,
                     input logic [31:0] d, input logic [3:0] cr, input logic [3:0] oc,
                     input logic vl, input logic ov, input logic ce, input logic [31:0] q);
    vec_t e;
    e.rst_n = r; e.issue = iss; e.in_vld = iv; e.out_rdy = rdy; e.din = d;
    e.credit = cr; e.occ = oc; e.vld = vl; e.ovf = ov; e.cerr = ce; e.dout = q;
    v.push_back(e);
  endtask
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic iss, input logic iv, input logic rdy, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; b.issue = iss; b.in_vld = iv; b.out_rdy = rdy; b.in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check_state(input int idx, input logic [3:0] cr, input logic [3:0] oc,
                             input logic vl, input logic ov, input logic ce, input logic [31:0] q);
    chk("credit_r", idx, 32'(b.credit_r), 32'(cr));
    chk("credit_avail", idx, 32'(b.credit_avail), 32'(cr != 0));
    chk("occ_r", idx, 32'(b.occ_r), 32'(oc));
    chk("out_vld_r", idx, 32'(b.out_vld_r), 32'(vl));
    chk("err_ovf_r", idx, 32'(b.err_ovf_r), 32'(ov));
    chk("err_credit_r", idx, 32'(b.err_credit_r), 32'(ce));
    if (vl) chk("out_r", idx, b.out_r, q);
  endtask
  initial begin
    rst_n = 1'b0; b.issue = 1'b0; b.in_vld = 1'b0; b.out_rdy = 1'b0; b.in = '0;
    add(0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 32'hA5A5_0001, 7, 1, 1, 0, 0, 32'hA5A5_0001);
    add(1, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(1, 1, 1, 0, 32'hD000_0000 + 32'(i), 4'(7 - i), 4'(i + 1), 1, 0, 0, 32'hD000_0000);
    add(1, 1, 0, 0, 0, 0, 8, 1, 0, 1, 32'hD000_0000);
    add(1, 0, 1, 1, 32'hE000_0000, 1, 8, 1, 0, 1, 32'hD000_0001);
    add(1, 0, 1, 0, 32'hBAD0_BAD0, 1, 8, 1, 1, 1, 32'hD000_0001);
    for (int j = 0; j < 3; j++)
      add(1, 0, 0, 1, 0, 4'(2 + j), 4'(7 - j), 1, 1, 1, 32'hD000_0002 + 32'(j));
    for (int k = 0; k < 3; k++)
      add(1, 1, 0, 0, 0, 4'(3 - k), 5, 1, 1, 1, 32'hD000_0004);
    add(0, 1, 1, 1, 32'hFFFF_FFFF, 8, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'hC000_0001, 7, 1, 1, 0, 0, 32'hC000_0001);
    add(1, 1, 0, 1, 0, 7, 0, 0, 0, 0, 0);
    foreach (v[i]) begin
      drive(v[i].rst_n, v[i].issue, v[i].in_vld, v[i].out_rdy, v[i].din);
      check_state(i, v[i].credit, v[i].occ, v[i].vld, v[i].ovf, v[i].cerr, v[i].dout);
    end
    // streaming at occupancy 1: pointers wrap while never full
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 1, 1, 32'hF000_0000 + 32'(i));
      check_state(100 + i, 6, 1, 1, 0, 0, 32'hF000_0000 + 32'(i));
    end
    drive(1, 0, 0, 1, 0);
    check_state(200, 7, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
